// File: rtl/axis_div_pkg.sv
// Shared definitions for the multi-axis divider PIO: register map offsets
// and a small elaboration-time helper.
package axis_div_pkg;

    // Divider registers start at word 0, one word per channel.
    localparam int DIV_BASE = 0;

    // Enable mask sits directly after the last divider word.
    function automatic int en_ofs(input int n_ch);
        return DIV_BASE + n_ch;
    endfunction

    // Sticky tick status follows the enable mask.
    function automatic int stat_ofs(input int n_ch);
        return DIV_BASE + n_ch + 1;
    endfunction

    // Ceiling log2, used when sizing the word address.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/axis_div_chan.sv
// One axis of the divider: free-running counter, registered tick and the
// active divider. Optional macro AXIS_DIV_SHADOW_EN adds a pending divider
// register so period changes only land on a terminal count.
module axis_div_chan
    import axis_div_pkg::*;
#(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             wr,
    input  logic [DIV_W-1:0] wdata,
    output logic             tick,
    output logic [DIV_W-1:0] div_act
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_act_q, div_act_d;
    logic             tick_q, tick_d;
    logic             term;
`ifdef AXIS_DIV_SHADOW_EN
    logic [DIV_W-1:0] div_pend_q, div_pend_d;
`endif

    // Terminal count: the cycle whose edge emits a tick and rewinds the counter.
    assign term = en && (cnt_q == div_act_q);

    // Counter/tick next state and divider update policy.
    always_comb begin
        cnt_d     = '0;
        tick_d    = 1'b0;
        div_act_d = div_act_q;
        if (en) begin
            tick_d = term;
            cnt_d  = term ? '0 : cnt_q + 1'b1;
        end
`ifdef AXIS_DIV_SHADOW_EN
        // Pending always tracks the last write; when idle it equals div_act.
        div_pend_d = wr ? wdata : div_pend_q;
        // Swap only at a period boundary (or while stopped) so no period is cut.
        if (!en || term)
            div_act_d = wr ? wdata : div_pend_q;
`else
        // Immediate update: restart the period from zero on the new divider.
        if (wr) begin
            div_act_d = wdata;
            cnt_d     = '0;
        end
`endif
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            div_act_q  <= '0;
`ifdef AXIS_DIV_SHADOW_EN
            div_pend_q <= '0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            div_act_q  <= div_act_d;
`ifdef AXIS_DIV_SHADOW_EN
            div_pend_q <= div_pend_d;
`endif
        end
    end

    assign tick    = tick_q;
    assign div_act = div_act_q;

endmodule

// File: rtl/axis_div_pio_multi.sv
// Multi-axis divider PIO on an Avalon-MM slave: N_CH divider words, an enable
// mask and a write-1-to-clear sticky tick status. Build macro
// AXIS_DIV_SHADOW_EN selects glitch-free (terminal-count) divider updates.
module axis_div_pio_multi
    import axis_div_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DIV_W  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic                  read_n,
    input  logic [DATA_W-1:0]     writedata,
    output logic [DATA_W-1:0]     readdata,
    output logic [N_CH-1:0]       tick_out,
    output logic [N_CH*DIV_W-1:0] out_port
);

    localparam logic [ADDR_W-1:0] EN_ADDR   = ADDR_W'(en_ofs(N_CH));
    localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(stat_ofs(N_CH));

    logic                       wr, rd;
    logic [N_CH-1:0]            wr_div;
    logic [N_CH-1:0]            tick;
    logic [N_CH-1:0][DIV_W-1:0] div_act;
    logic [N_CH-1:0]            en_q, en_d;
    logic [N_CH-1:0]            status_q, status_d;
    logic [DATA_W-1:0]          readdata_q, readdata_d;
    logic [DATA_W-1:0]          rd_val;
    logic                       unused_wdata;

    assign wr = chipselect & ~write_n;
    assign rd = chipselect & ~read_n;

    // Upper write-data bits beyond the widest field are don't-care.
    assign unused_wdata = ^writedata;

    genvar i;
    generate
        for (i = 0; i < N_CH; i++) begin : g_ch
            assign wr_div[i] = wr && (address == ADDR_W'(DIV_BASE + i));
            axis_div_chan #(.DIV_W(DIV_W)) u_chan (
                .clk     (clk),
                .reset   (reset),
                .en      (en_q[i]),
                .wr      (wr_div[i]),
                .wdata   (writedata[DIV_W-1:0]),
                .tick    (tick[i]),
                .div_act (div_act[i])
            );
        end
    endgenerate

    // Enable and status next state; a tick setting status beats a clear.
    always_comb begin
        en_d     = en_q;
        status_d = status_q;
        if (wr && address == EN_ADDR)
            en_d = writedata[N_CH-1:0];
        if (wr && address == STAT_ADDR)
            status_d = status_q & ~writedata[N_CH-1:0];
        status_d = status_d | tick;
    end

    // Read mux on pre-write register values; readdata holds between reads.
    always_comb begin
        rd_val = '0;
        for (int c = 0; c < N_CH; c++)
            if (address == ADDR_W'(DIV_BASE + c))
                rd_val = DATA_W'(div_act[c]);
        if (address == EN_ADDR)
            rd_val = DATA_W'(en_q);
        if (address == STAT_ADDR)
            rd_val = DATA_W'(status_q);
        readdata_d = rd ? rd_val : readdata_q;
    end

    // Top-level register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q       <= '0;
            status_q   <= '0;
            readdata_q <= '0;
        end else begin
            en_q       <= en_d;
            status_q   <= status_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign tick_out = tick;
    assign out_port = div_act;

endmodule
